// File: rtl/rvfi_retire_tracker.sv
// RVFI (NRET=1) retirement trace producer: in-order shadow queue filled at issue, drained at commit.
// Optional memory fields in the record are enabled by defining RVFI_TRACKER_MEM_EN.
module rvfi_retire_tracker #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [31:0]     iss_insn,
  input  logic [XLEN-1:0] iss_pc,
  input  logic [4:0]      iss_rs1_addr,
  input  logic [4:0]      iss_rs2_addr,
  input  logic [XLEN-1:0] iss_rs1_rdata,
  input  logic [XLEN-1:0] iss_rs2_rdata,
  input  logic            cmt_valid,
  input  logic            cmt_trap,
  input  logic [4:0]      cmt_rd_addr,
  input  logic [XLEN-1:0] cmt_rd_wdata,
  input  logic [XLEN-1:0] cmt_next_pc,
  input  logic            flush,
  output logic            rvfi_valid,
  output logic [63:0]     rvfi_order,
  output logic [31:0]     rvfi_insn,
  output logic            rvfi_trap,
  output logic [XLEN-1:0] rvfi_pc_rdata,
  output logic [XLEN-1:0] rvfi_pc_wdata,
  output logic [4:0]      rvfi_rs1_addr,
  output logic [4:0]      rvfi_rs2_addr,
  output logic [4:0]      rvfi_rd_addr,
  output logic [XLEN-1:0] rvfi_rs1_rdata,
  output logic [XLEN-1:0] rvfi_rs2_rdata,
  output logic [XLEN-1:0] rvfi_rd_wdata,
`ifdef RVFI_TRACKER_MEM_EN
  input  logic [XLEN-1:0]   cmt_mem_addr,
  input  logic [XLEN/8-1:0] cmt_mem_rmask,
  input  logic [XLEN/8-1:0] cmt_mem_wmask,
  input  logic [XLEN-1:0]   cmt_mem_rdata,
  input  logic [XLEN-1:0]   cmt_mem_wdata,
  output logic [XLEN-1:0]   rvfi_mem_addr,
  output logic [XLEN/8-1:0] rvfi_mem_rmask,
  output logic [XLEN/8-1:0] rvfi_mem_wmask,
  output logic [XLEN-1:0]   rvfi_mem_rdata,
  output logic [XLEN-1:0]   rvfi_mem_wdata,
`endif
  output logic            protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]     q_insn_r      [DEPTH];
  logic [XLEN-1:0] q_pc_r        [DEPTH];
  logic [4:0]      q_rs1_addr_r  [DEPTH];
  logic [4:0]      q_rs2_addr_r  [DEPTH];
  logic [XLEN-1:0] q_rs1_rdata_r [DEPTH];
  logic [XLEN-1:0] q_rs2_rdata_r [DEPTH];

  logic [AW-1:0]   head_r;
  logic [AW-1:0]   tail_r;
  logic [AW:0]     count_r;
  logic [63:0]     order_r;

  logic            issue_s;
  logic            commit_s;
  logic            empty_cmt_s;
  logic [AW-1:0]   head_next_s;
  logic [AW-1:0]   tail_next_s;
  logic [AW:0]     count_next_s;
  logic [XLEN-1:0] rs1_cap_s;
  logic [XLEN-1:0] rs2_cap_s;
  logic [4:0]      rd_addr_s;
  logic [XLEN-1:0] rd_wdata_s;

  // Handshake decode, pointer/count next state and zero-register/trap masking
  always_comb begin
    issue_s      = 1'b0;
    commit_s     = 1'b0;
    empty_cmt_s  = 1'b0;
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    count_next_s = count_r;
    rs1_cap_s    = iss_rs1_rdata;
    rs2_cap_s    = iss_rs2_rdata;
    rd_addr_s    = cmt_rd_addr;
    rd_wdata_s   = cmt_rd_wdata;

    issue_s     = iss_valid && iss_ready && !flush;
    commit_s    = cmt_valid && (count_r != {(AW+1){1'b0}});
    empty_cmt_s = cmt_valid && (count_r == {(AW+1){1'b0}});

    // Flush wins over both pointers: the commit already popped, the issue is dropped
    if (flush) begin
      head_next_s  = tail_r;
      tail_next_s  = tail_r;
      count_next_s = {(AW+1){1'b0}};
    end else begin
      if (commit_s) begin
        head_next_s = head_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        head_next_s = head_r;
      end
      if (issue_s) begin
        tail_next_s = tail_r + {{(AW-1){1'b0}}, 1'b1};
      end else begin
        tail_next_s = tail_r;
      end
      case ({issue_s, commit_s})
        2'b10:   count_next_s = count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_next_s = count_r - {{AW{1'b0}}, 1'b1};
        default: count_next_s = count_r;
      endcase
    end

    if (iss_rs1_addr == 5'd0) begin
      rs1_cap_s = {XLEN{1'b0}};
    end else begin
      rs1_cap_s = iss_rs1_rdata;
    end
    if (iss_rs2_addr == 5'd0) begin
      rs2_cap_s = {XLEN{1'b0}};
    end else begin
      rs2_cap_s = iss_rs2_rdata;
    end
    if (cmt_trap || (cmt_rd_addr == 5'd0)) begin
      rd_addr_s  = 5'd0;
      rd_wdata_s = {XLEN{1'b0}};
    end else begin
      rd_addr_s  = cmt_rd_addr;
      rd_wdata_s = cmt_rd_wdata;
    end
  end

  // Shadow queue storage, written at the tail on an accepted issue
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_insn_r[i]      <= 32'd0;
        q_pc_r[i]        <= {XLEN{1'b0}};
        q_rs1_addr_r[i]  <= 5'd0;
        q_rs2_addr_r[i]  <= 5'd0;
        q_rs1_rdata_r[i] <= {XLEN{1'b0}};
        q_rs2_rdata_r[i] <= {XLEN{1'b0}};
      end
    end else if (issue_s) begin
      q_insn_r[tail_r]      <= iss_insn;
      q_pc_r[tail_r]        <= iss_pc;
      q_rs1_addr_r[tail_r]  <= iss_rs1_addr;
      q_rs2_addr_r[tail_r]  <= iss_rs2_addr;
      q_rs1_rdata_r[tail_r] <= rs1_cap_s;
      q_rs2_rdata_r[tail_r] <= rs2_cap_s;
    end
  end

  // Queue control, retirement counter, ready flag and sticky protocol error
  always_ff @(posedge clock) begin
    if (reset) begin
      head_r       <= {AW{1'b0}};
      tail_r       <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
      order_r      <= 64'd0;
      iss_ready    <= 1'b1;
      protocol_err <= 1'b0;
    end else begin
      head_r       <= head_next_s;
      tail_r       <= tail_next_s;
      count_r      <= count_next_s;
      iss_ready    <= (count_next_s != FULL_CNT);
      protocol_err <= protocol_err | empty_cmt_s;
      if (commit_s) begin
        order_r <= order_r + 64'd1;
      end
    end
  end

  // Retirement record: valid pulses one cycle, other fields hold until the next commit
  always_ff @(posedge clock) begin
    if (reset) begin
      rvfi_valid     <= 1'b0;
      rvfi_order     <= 64'd0;
      rvfi_insn      <= 32'd0;
      rvfi_trap      <= 1'b0;
      rvfi_pc_rdata  <= {XLEN{1'b0}};
      rvfi_pc_wdata  <= {XLEN{1'b0}};
      rvfi_rs1_addr  <= 5'd0;
      rvfi_rs2_addr  <= 5'd0;
      rvfi_rd_addr   <= 5'd0;
      rvfi_rs1_rdata <= {XLEN{1'b0}};
      rvfi_rs2_rdata <= {XLEN{1'b0}};
      rvfi_rd_wdata  <= {XLEN{1'b0}};
`ifdef RVFI_TRACKER_MEM_EN
      rvfi_mem_addr  <= {XLEN{1'b0}};
      rvfi_mem_rmask <= {(XLEN/8){1'b0}};
      rvfi_mem_wmask <= {(XLEN/8){1'b0}};
      rvfi_mem_rdata <= {XLEN{1'b0}};
      rvfi_mem_wdata <= {XLEN{1'b0}};
`endif
    end else begin
      rvfi_valid <= commit_s;
      if (commit_s) begin
        rvfi_order     <= order_r;
        rvfi_insn      <= q_insn_r[head_r];
        rvfi_trap      <= cmt_trap;
        rvfi_pc_rdata  <= q_pc_r[head_r];
        rvfi_pc_wdata  <= cmt_next_pc;
        rvfi_rs1_addr  <= q_rs1_addr_r[head_r];
        rvfi_rs2_addr  <= q_rs2_addr_r[head_r];
        rvfi_rd_addr   <= rd_addr_s;
        rvfi_rs1_rdata <= q_rs1_rdata_r[head_r];
        rvfi_rs2_rdata <= q_rs2_rdata_r[head_r];
        rvfi_rd_wdata  <= rd_wdata_s;
`ifdef RVFI_TRACKER_MEM_EN
        rvfi_mem_addr  <= cmt_mem_addr;
        rvfi_mem_rmask <= cmt_trap ? {(XLEN/8){1'b0}} : cmt_mem_rmask;
        rvfi_mem_wmask <= cmt_trap ? {(XLEN/8){1'b0}} : cmt_mem_wmask;
        rvfi_mem_rdata <= cmt_mem_rdata;
        rvfi_mem_wdata <= cmt_mem_wdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rvfi_retire_tracker.sv
// Scoreboard bench for rvfi_retire_tracker: a reference queue model predicts each record at commit.
module tb_rvfi_retire_tracker;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            iss_valid, iss_ready;
  logic [31:0]     iss_insn;
  logic [XLEN-1:0] iss_pc, iss_rs1_rdata, iss_rs2_rdata;
  logic [4:0]      iss_rs1_addr, iss_rs2_addr;
  logic            cmt_valid, cmt_trap, flush;
  logic [4:0]      cmt_rd_addr;
  logic [XLEN-1:0] cmt_rd_wdata, cmt_next_pc;
  logic            rvfi_valid, rvfi_trap, protocol_err;
  logic [63:0]     rvfi_order;
  logic [31:0]     rvfi_insn;
  logic [XLEN-1:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [4:0]      rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
`ifdef RVFI_TRACKER_MEM_EN
  logic [XLEN-1:0]   cmt_mem_addr, cmt_mem_rdata, cmt_mem_wdata;
  logic [XLEN/8-1:0] cmt_mem_rmask, cmt_mem_wmask;
  logic [XLEN-1:0]   rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [XLEN/8-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
`endif

  always #5 clock = ~clock;

  rvfi_retire_tracker #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_insn(iss_insn), .iss_pc(iss_pc),
    .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
    .iss_rs1_rdata(iss_rs1_rdata), .iss_rs2_rdata(iss_rs2_rdata),
    .cmt_valid(cmt_valid), .cmt_trap(cmt_trap), .cmt_rd_addr(cmt_rd_addr),
    .cmt_rd_wdata(cmt_rd_wdata), .cmt_next_pc(cmt_next_pc), .flush(flush),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_wdata(rvfi_rd_wdata),
`ifdef RVFI_TRACKER_MEM_EN
    .cmt_mem_addr(cmt_mem_addr), .cmt_mem_rmask(cmt_mem_rmask), .cmt_mem_wmask(cmt_mem_wmask),
    .cmt_mem_rdata(cmt_mem_rdata), .cmt_mem_wdata(cmt_mem_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
`endif
    .protocol_err(protocol_err)
  );

  typedef struct {
    logic [31:0] insn;
    logic [31:0] pc;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
  } ent_t;

  typedef struct {
    logic [63:0] order;
    ent_t        e;
    logic        trap;
    logic [4:0]  rda;
    logic [31:0] rdd;
    logic [31:0] npc;
  } rec_t;

  ent_t        mq[$];
  rec_t        exp_q[$];
  rec_t        last_rec;
  logic [63:0] morder;
  logic        merr;
  int          total = 0;
  int          bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_insn = 32'd0; iss_pc = 32'd0;
    iss_rs1_addr = 5'd0; iss_rs2_addr = 5'd0; iss_rs1_rdata = 32'd0; iss_rs2_rdata = 32'd0;
    cmt_valid = 1'b0; cmt_trap = 1'b0; cmt_rd_addr = 5'd0; cmt_rd_wdata = 32'd0;
    cmt_next_pc = 32'd0; flush = 1'b0;
`ifdef RVFI_TRACKER_MEM_EN
    cmt_mem_addr = '0; cmt_mem_rmask = '0; cmt_mem_wmask = '0;
    cmt_mem_rdata = '0; cmt_mem_wdata = '0;
`endif
  endtask

  task automatic set_iss(input logic [31:0] insn, input logic [31:0] pc,
                         input logic [4:0] r1a, input logic [31:0] r1d,
                         input logic [4:0] r2a, input logic [31:0] r2d);
    iss_valid = 1'b1; iss_insn = insn; iss_pc = pc;
    iss_rs1_addr = r1a; iss_rs1_rdata = r1d; iss_rs2_addr = r2a; iss_rs2_rdata = r2d;
  endtask

  task automatic set_cmt(input logic trap, input logic [4:0] rda,
                         input logic [31:0] rdd, input logic [31:0] npc);
    cmt_valid = 1'b1; cmt_trap = trap; cmt_rd_addr = rda; cmt_rd_wdata = rdd; cmt_next_pc = npc;
  endtask

  task automatic clear_model();
    mq.delete();
    exp_q.delete();
    morder = 64'd0;
    merr = 1'b0;
    last_rec.order = 64'd0; last_rec.e.insn = 32'd0; last_rec.e.pc = 32'd0;
    last_rec.e.rs1a = 5'd0; last_rec.e.rs2a = 5'd0; last_rec.e.rs1d = 32'd0;
    last_rec.e.rs2d = 32'd0; last_rec.trap = 1'b0; last_rec.rda = 5'd0;
    last_rec.rdd = 32'd0; last_rec.npc = 32'd0;
  endtask

  // One clock: update the model with the driven inputs, then check the DUT after the edge.
  task automatic tick();
    bit   rdy, do_c, do_i;
    ent_t e;
    rec_t r;
    rdy  = (mq.size() != DEPTH);
    check_eq("iss_ready", 64'(iss_ready), 64'(rdy));
    do_c = cmt_valid && (mq.size() != 0);
    do_i = iss_valid && rdy && !flush;
    if (cmt_valid && (mq.size() == 0)) merr = 1'b1;
    if (do_c) begin
      e       = mq.pop_front();
      r.order = morder;
      r.e     = e;
      r.trap  = cmt_trap;
      r.rda   = cmt_trap ? 5'd0 : cmt_rd_addr;
      r.rdd   = (cmt_trap || cmt_rd_addr == 5'd0) ? 32'd0 : cmt_rd_wdata;
      r.npc   = cmt_next_pc;
      exp_q.push_back(r);
      morder  = morder + 64'd1;
    end
    if (do_i) begin
      e.insn = iss_insn; e.pc = iss_pc; e.rs1a = iss_rs1_addr; e.rs2a = iss_rs2_addr;
      e.rs1d = (iss_rs1_addr == 5'd0) ? 32'd0 : iss_rs1_rdata;
      e.rs2d = (iss_rs2_addr == 5'd0) ? 32'd0 : iss_rs2_rdata;
      mq.push_back(e);
    end
    if (flush) mq.delete();
    @(posedge clock);
    #1;
    idle();
    check_eq("rvfi_valid", 64'(rvfi_valid), 64'(exp_q.size() != 0));
    if (rvfi_valid && exp_q.size() != 0) begin
      r = exp_q.pop_front();
      last_rec = r;
      check_eq("order", rvfi_order, r.order);
      check_eq("insn", 64'(rvfi_insn), 64'(r.e.insn));
      check_eq("trap", 64'(rvfi_trap), 64'(r.trap));
      check_eq("pc_rdata", 64'(rvfi_pc_rdata), 64'(r.e.pc));
      check_eq("pc_wdata", 64'(rvfi_pc_wdata), 64'(r.npc));
      check_eq("rs1_addr", 64'(rvfi_rs1_addr), 64'(r.e.rs1a));
      check_eq("rs2_addr", 64'(rvfi_rs2_addr), 64'(r.e.rs2a));
      check_eq("rs1_rdata", 64'(rvfi_rs1_rdata), 64'(r.e.rs1d));
      check_eq("rs2_rdata", 64'(rvfi_rs2_rdata), 64'(r.e.rs2d));
      check_eq("rd_addr", 64'(rvfi_rd_addr), 64'(r.rda));
      check_eq("rd_wdata", 64'(rvfi_rd_wdata), 64'(r.rdd));
    end else begin
      exp_q.delete();
      check_eq("hold_order", rvfi_order, last_rec.order);
      check_eq("hold_insn", 64'(rvfi_insn), 64'(last_rec.e.insn));
      check_eq("hold_rd_wdata", 64'(rvfi_rd_wdata), 64'(last_rec.rdd));
    end
    check_eq("protocol_err", 64'(protocol_err), 64'(merr));
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_model();
    check_eq("rst_valid", 64'(rvfi_valid), 64'd0);
    check_eq("rst_order", rvfi_order, 64'd0);
    check_eq("rst_pc_wdata", 64'(rvfi_pc_wdata), 64'd0);
    check_eq("rst_rd_wdata", 64'(rvfi_rd_wdata), 64'd0);
    check_eq("rst_perr", 64'(protocol_err), 64'd0);
    check_eq("rst_ready", 64'(iss_ready), 64'd1);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    do_reset();

    // basic issue then commit
    set_iss(32'h0050_0093, 32'h100, 5'd2, 32'd7, 5'd0, 32'd0); tick();
    set_cmt(1'b0, 5'd1, 32'd12, 32'h104); tick();
    tick();

    // fill to full, then issue+commit while full
    for (int i = 0; i < DEPTH; i++) begin
      set_iss(32'h1000 + 32'(i), 32'h200 + 32'(4*i), 5'(i+1), 32'(100+i), 5'(i+3), 32'(200+i));
      tick();
    end
    set_iss(32'hbad0, 32'h300, 5'd1, 32'd1, 5'd1, 32'd1);
    set_cmt(1'b0, 5'd4, 32'd44, 32'h204); tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      set_cmt(1'b0, 5'(i+5), 32'(50+i), 32'(32'h208 + 32'(4*i))); tick();
    end

    // zero-register rules
    set_iss(32'h2222, 32'h400, 5'd6, 32'h66, 5'd0, 32'h55); tick();
    set_cmt(1'b0, 5'd0, 32'hdead, 32'h404); tick();

    // trap commit
    set_iss(32'h3333, 32'h500, 5'd7, 32'h77, 5'd8, 32'h88); tick();
    set_cmt(1'b1, 5'd3, 32'h1234, 32'h800); tick();

    // flush with same-cycle commit and issue, then commit on empty queue
    for (int i = 0; i < 3; i++) begin
      set_iss(32'h4000 + 32'(i), 32'h600 + 32'(4*i), 5'd9, 32'(i), 5'd10, 32'(i)); tick();
    end
    set_iss(32'h4fff, 32'h700, 5'd1, 32'd1, 5'd1, 32'd1);
    set_cmt(1'b0, 5'd11, 32'h99, 32'h604); flush = 1'b1; tick();
    set_cmt(1'b0, 5'd12, 32'h98, 32'h608); tick();
    // issue into empty queue with a same-cycle commit
    set_iss(32'h5000, 32'h900, 5'd13, 32'h13, 5'd14, 32'h14);
    set_cmt(1'b0, 5'd15, 32'h15, 32'h904); tick();
    set_cmt(1'b0, 5'd16, 32'h16, 32'h904); tick();

    // random traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0)
        set_iss($urandom, $urandom, 5'($urandom_range(0, 3)), $urandom,
                5'($urandom_range(0, 3)), $urandom);
      if ($urandom_range(0, 2) == 0)
        set_cmt(1'($urandom_range(0, 5) == 0), 5'($urandom_range(0, 3)), $urandom, $urandom);
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end

    // reset with entries queued, then order restarts at 0
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_iss(32'h6000 + 32'(i), 32'ha00, 5'd1, 32'd1, 5'd2, 32'd2); tick();
    end
    do_reset();
    set_iss(32'h7000, 32'hb00, 5'd3, 32'd3, 5'd4, 32'd4); tick();
    set_cmt(1'b0, 5'd5, 32'd5, 32'hb04); tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
